decode_stage: RTL and testbench

Instruction decode stage directly upstream of the register file. Accepts one RV32I instruction per cycle over a valid/ready handshake and drives the register file read addresses. Holds the decoded fields for one cycle so they line up with the file's registered read data. Adds write-through bypass and x0 forcing, and presents fully resolved operands, immediate and control to the execute stage.

---
 rtl/decode_pkg.sv | 41 ++++
 rtl/decode_stage_imm_gen.sv | 46 ++++
 rtl/decode_stage.sv | 153 +++++++++++++++
 tb/tb_decode_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the RV32I decode stage.
//   opclass_t  - instruction class presented to execute (4 bits)
//   imm_fmt_t  - immediate encoding format selected by the opcode
//   decoded_t  - instruction-derived control fields held in the decode slot
//   OPC_*      - RV32I major opcodes (instr[6:0])
package decode_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, ILLEGAL
  } opclass_t;

  typedef enum logic [2:0] {
    FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              funct7b5;
    opclass_t          opclass;
    logic              reg_write;
    logic              illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
//   instr - instruction word
//   fmt   - immediate format chosen by the decoder
//   imm   - immediate, sign-extended from instr[31] to WORD_WIDTH
//           (FMT_NONE yields zero)
module imm_gen
  import decode_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic [WORD_WIDTH-1:0] instr,
  input  imm_fmt_t              fmt,
  output logic [WORD_WIDTH-1:0] imm
);

  // Each format is assembled at its natural width as a signed value so the
  // width cast below performs the sign extension from instr[31].
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic               unused_opcode;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // The major opcode never contributes immediate bits.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = WORD_WIDTH'(imm_i);
      FMT_S:   imm = WORD_WIDTH'(imm_s);
      FMT_B:   imm = WORD_WIDTH'(imm_b);
      FMT_U:   imm = WORD_WIDTH'(imm_u);
      FMT_J:   imm = WORD_WIDTH'(imm_j);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage in front of a register file with a
// one-cycle registered read.
//   in_valid/in_ready/in_instr/in_pc - fetch handshake and instruction
//   flush                            - drop held and incoming instruction
//   ra1/ra2, rd1/rd2                 - register file read address / data
//   wb_wen/wb_addr/wb_data           - writeback port, snooped for bypass
//   out_valid/out_ready              - execute handshake
//   out_pc/out_imm/out_op_a/out_op_b - resolved PC, immediate, operands
//   out_rd/out_opclass/out_funct3/out_funct7b5/out_reg_write/out_illegal
//                                    - decoded control
// A single slot holds the decoded instruction; its source addresses drive
// the register file while it waits, so operands track late writebacks.
module decode_stage
  import decode_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_WIDTH-1:0]    in_instr,
  input  logic [WORD_WIDTH-1:0]    in_pc,
  input  logic                     flush,
  output logic [ADDRESS_WIDTH-1:0] ra1,
  output logic [ADDRESS_WIDTH-1:0] ra2,
  input  logic [WORD_WIDTH-1:0]    rd1,
  input  logic [WORD_WIDTH-1:0]    rd2,
  input  logic                     wb_wen,
  input  logic [ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [WORD_WIDTH-1:0]    wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_pc,
  output logic [WORD_WIDTH-1:0]    out_imm,
  output logic [WORD_WIDTH-1:0]    out_op_a,
  output logic [WORD_WIDTH-1:0]    out_op_b,
  output logic [ADDRESS_WIDTH-1:0] out_rd,
  output opclass_t                 out_opclass,
  output logic [2:0]               out_funct3,
  output logic                     out_funct7b5,
  output logic                     out_reg_write,
  output logic                     out_illegal
);

  decoded_t                 dec_p0;
  imm_fmt_t                 fmt_p0;
  logic [WORD_WIDTH-1:0]    imm_p0;
  logic                     writes_rd_p0;
  logic                     accept;

  decoded_t                 slot_p1;
  logic [WORD_WIDTH-1:0]    pc_p1;
  logic [WORD_WIDTH-1:0]    imm_p1;
  logic                     vld_p1;
  logic                     byp1;
  logic                     byp2;
  logic [WORD_WIDTH-1:0]    bdat1;
  logic [WORD_WIDTH-1:0]    bdat2;

  // ---- p0: decode of the incoming instruction ----
  always_comb begin
    dec_p0          = '0;
    fmt_p0          = FMT_NONE;
    writes_rd_p0    = 1'b0;
    dec_p0.rs1      = in_instr[19:15];
    dec_p0.rs2      = in_instr[24:20];
    dec_p0.rd       = in_instr[11:7];
    dec_p0.funct3   = in_instr[14:12];
    dec_p0.funct7b5 = in_instr[30];
    case (in_instr[6:0])
      OPC_LUI:    begin dec_p0.opclass = LUI;    fmt_p0 = FMT_U; writes_rd_p0 = 1'b1; end
      OPC_AUIPC:  begin dec_p0.opclass = AUIPC;  fmt_p0 = FMT_U; writes_rd_p0 = 1'b1; end
      OPC_JAL:    begin dec_p0.opclass = JAL;    fmt_p0 = FMT_J; writes_rd_p0 = 1'b1; end
      OPC_JALR:   begin dec_p0.opclass = JALR;   fmt_p0 = FMT_I; writes_rd_p0 = 1'b1; end
      OPC_BRANCH: begin dec_p0.opclass = BRANCH; fmt_p0 = FMT_B; end
      OPC_LOAD:   begin dec_p0.opclass = LOAD;   fmt_p0 = FMT_I; writes_rd_p0 = 1'b1; end
      OPC_STORE:  begin dec_p0.opclass = STORE;  fmt_p0 = FMT_S; end
      OPC_OPIMM:  begin dec_p0.opclass = OPIMM;  fmt_p0 = FMT_I; writes_rd_p0 = 1'b1; end
      OPC_OP:     begin dec_p0.opclass = OP;     writes_rd_p0 = 1'b1; end
      OPC_FENCE:  begin dec_p0.opclass = FENCE;  end
      // CSR forms write rd; ECALL/EBREAK encode rd = x0 and fall out below.
      OPC_SYSTEM: begin dec_p0.opclass = SYSTEM; writes_rd_p0 = 1'b1; end
      default:    begin dec_p0.opclass = ILLEGAL; dec_p0.illegal = 1'b1; end
    endcase
    dec_p0.reg_write = writes_rd_p0 && (dec_p0.rd != '0);
  end

  imm_gen #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt_p0),
    .imm   (imm_p0)
  );

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // While nothing is accepted the held instruction re-reads its sources.
  assign ra1 = accept ? ADDRESS_WIDTH'(dec_p0.rs1) : ADDRESS_WIDTH'(slot_p1.rs1);
  assign ra2 = accept ? ADDRESS_WIDTH'(dec_p0.rs2) : ADDRESS_WIDTH'(slot_p1.rs2);

  // ---- p1: slot register, aligned with the registered read data ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      slot_p1 <= '0;
      pc_p1   <= '0;
      imm_p1  <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      slot_p1 <= dec_p0;
      pc_p1   <= in_pc;
      imm_p1  <= imm_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // The register file reads the old value when written on the same edge it
  // samples the address, so the writeback is captured here instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp1  <= 1'b0;
      byp2  <= 1'b0;
      bdat1 <= '0;
      bdat2 <= '0;
    end else begin
      byp1  <= wb_wen && (wb_addr == ra1) && (ra1 != '0);
      byp2  <= wb_wen && (wb_addr == ra2) && (ra2 != '0);
      bdat1 <= wb_data;
      bdat2 <= wb_data;
    end
  end

  assign out_op_a = (slot_p1.rs1 == '0) ? '0 : (byp1 ? bdat1 : rd1);
  assign out_op_b = (slot_p1.rs2 == '0) ? '0 : (byp2 ? bdat2 : rd2);

  assign out_valid     = vld_p1;
  assign out_pc        = pc_p1;
  assign out_imm       = imm_p1;
  assign out_rd        = ADDRESS_WIDTH'(slot_p1.rd);
  assign out_opclass   = slot_p1.opclass;
  assign out_funct3    = slot_p1.funct3;
  assign out_funct7b5  = slot_p1.funct7b5;
  assign out_reg_write = slot_p1.reg_write;
  assign out_illegal   = slot_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a small register
// file model (registered read, old value on same-edge write).
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [4:0]  out_rd;
  opclass_t    out_opclass;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_reg_write;
  logic        out_illegal;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [32] = '{default: '0};

  decode_stage #(
    .WORD_WIDTH    (32),
    .ADDRESS_WIDTH (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .flush         (flush),
    .ra1           (ra1),
    .ra2           (ra2),
    .rd1           (rd1),
    .rd2           (rd2),
    .wb_wen        (wb_wen),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_imm       (out_imm),
    .out_op_a      (out_op_a),
    .out_op_b      (out_op_b),
    .out_rd        (out_rd),
    .out_opclass   (out_opclass),
    .out_funct3    (out_funct3),
    .out_funct7b5  (out_funct7b5),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wb_wen && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
    rd1 <= rf[ra1];
    rd2 <= rf[ra2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1; wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ra1", 32'(ra1), 32'd0);
    check("rst_ra2", 32'(ra2), 32'd0);
    step(); step();
    rst = 1'b0;

    // preload x2 = 0x22
    wb_wen = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    step();
    wb_wen = 1'b0;

    // addi x5,x0,7
    in_valid = 1'b1; in_instr = 32'h00700293; in_pc = 32'h100;
    #1;
    check("addi_ra1", 32'(ra1), 32'd0);
    check("addi_ra2", 32'(ra2), 32'd7);
    step();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_rd", 32'(out_rd), 32'd5);
    check("addi_imm", out_imm, 32'd7);
    check("addi_op_a", out_op_a, 32'd0);
    check("addi_class", 32'(out_opclass), 32'(OPIMM));
    check("addi_rw", 32'(out_reg_write), 32'd1);
    check("addi_pc", out_pc, 32'h100);

    // add x3,x1,x2 accepted while x1 is being written
    in_instr = 32'h002081B3; in_pc = 32'h104;
    wb_wen = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEADBEEF;
    #1;
    check("add_ra1", 32'(ra1), 32'd1);
    step();
    wb_wen = 1'b0; out_ready = 1'b0;
    in_instr = 32'hFE000EE3; in_pc = 32'h108;
    #1;
    check("byp_op_a", out_op_a, 32'hDEADBEEF);
    check("add_op_b", out_op_b, 32'h22);
    check("add_rd", 32'(out_rd), 32'd3);
    check("add_class", 32'(out_opclass), 32'(OP));
    check("add_imm", out_imm, 32'd0);
    check("stall1_in_ready", 32'(in_ready), 32'd0);
    check("stall1_ra1", 32'(ra1), 32'd1);
    check("stall1_ra2", 32'(ra2), 32'd2);
    step();
    // stall cycle 2: write x2
    wb_wen = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    check("stall2_in_ready", 32'(in_ready), 32'd0);
    check("stall2_op_b", out_op_b, 32'h22);
    check("stall2_op_a", out_op_a, 32'hDEADBEEF);
    step();
    wb_wen = 1'b0;
    check("stall3_op_b", out_op_b, 32'h55);
    check("stall3_op_a", out_op_a, 32'hDEADBEEF);
    check("stall3_rd", 32'(out_rd), 32'd3);
    check("stall3_pc", out_pc, 32'h104);
    check("stall3_valid", 32'(out_valid), 32'd1);
    check("stall3_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();

    // beq x0,x0,-4
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_class", 32'(out_opclass), 32'(BRANCH));
    check("beq_rw", 32'(out_reg_write), 32'd0);
    check("beq_pc", out_pc, 32'h108);

    // flush with held and incoming instruction, execute stalled
    in_instr = 32'h00A00313; in_pc = 32'h10C; flush = 1'b1; out_ready = 1'b0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    step();
    check("flush_lost", 32'(out_valid), 32'd0);

    // illegal then back-to-back LUI, JAL, SW, addi x0
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h200;
    step();
    in_instr = 32'h123452B7; in_pc = 32'h204;
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_rw", 32'(out_reg_write), 32'd0);
    check("ill_class", 32'(out_opclass), 32'(ILLEGAL));
    check("ill_valid", 32'(out_valid), 32'd1);
    step();
    in_instr = 32'h008000EF; in_pc = 32'h208;
    check("lui_imm", out_imm, 32'h12345000);
    check("lui_class", 32'(out_opclass), 32'(LUI));
    check("lui_ill", 32'(out_illegal), 32'd0);
    check("lui_rw", 32'(out_reg_write), 32'd1);
    step();
    in_instr = 32'hFE20AC23; in_pc = 32'h20C;
    check("jal_imm", out_imm, 32'd8);
    check("jal_class", 32'(out_opclass), 32'(JAL));
    check("jal_rd", 32'(out_rd), 32'd1);
    check("jal_pc", out_pc, 32'h208);
    step();
    in_instr = 32'h00000013; in_pc = 32'h210;
    check("sw_imm", out_imm, 32'hFFFFFFF8);
    check("sw_class", 32'(out_opclass), 32'(STORE));
    check("sw_rw", 32'(out_reg_write), 32'd0);
    check("sw_funct3", 32'(out_funct3), 32'd2);
    step();
    in_valid = 1'b0;
    check("x0_rw", 32'(out_reg_write), 32'd0);
    check("x0_class", 32'(out_opclass), 32'(OPIMM));
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // reset while an instruction is stalled
    in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h300; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_f7b5", 32'(out_funct7b5), 32'd1);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    check("hold_ra1", 32'(ra1), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ra1", 32'(ra1), 32'd0);
    check("arst_ra2", 32'(ra2), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00700293; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    check("post_valid", 32'(out_valid), 32'd1);
    check("post_rd", 32'(out_rd), 32'd5);
    check("post_imm", out_imm, 32'd7);
    check("post_op_a", out_op_a, 32'd0);
    check("post_pc", out_pc, 32'h400);
    check("post_rw", 32'(out_reg_write), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
